// File: rtl/sd_write_crc_status_if.sv
// Signal bundle between the SD DAT receive stage / write path and the
// CRC-status token generator that drives DAT0 back to the host.
//
// Handshake semantics: there is no valid/ready pair here. write_all_strobe
// and abort are single-cycle request pulses in the system clock domain and
// are acted on in the cycle they are high; crc_ok is qualified only by
// write_all_strobe. busy_hold is a level that is sampled only on sd_clock
// falling edges while the line is held busy. status_done and crc_error are
// single-cycle completion pulses; overrun is a sticky flag. state_dbg
// mirrors the FSM state for observation only.
interface sd_write_crc_status_if;
    logic       sd_clock;
    logic       write_all_strobe;
    logic       crc_ok;
    logic       busy_hold;
    logic       abort;
    logic       dat0_out;
    logic       dat0_oe;
    logic       busy;
    logic       status_done;
    logic       crc_error;
    logic       overrun;
    logic [2:0] state_dbg;

    modport master (
        output sd_clock, write_all_strobe, crc_ok, busy_hold, abort,
        input  dat0_out, dat0_oe, busy, status_done, crc_error, overrun, state_dbg
    );

    modport slave (
        input  sd_clock, write_all_strobe, crc_ok, busy_hold, abort,
        output dat0_out, dat0_oe, busy, status_done, crc_error, overrun, state_dbg
    );
endinterface

// File: rtl/sd_write_crc_status.sv
// SD write CRC-status responder: after a received block, waits NCRC_EDGES
// sd_clock falling edges, drives the 5-bit CRC-status token on DAT0, holds
// the line low while the write path commits, then releases it. sd_clock is
// oversampled in the system clock domain; every DAT0 change happens on a
// detected falling edge so the host sees stable data at its rising edge.
module sd_write_crc_status #(
    parameter int unsigned NCRC_EDGES = 2,
    parameter int unsigned BUSY_MIN   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sd_write_crc_status_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_STAT  = 3'd3,
        S_END   = 3'd4,
        S_BUSY  = 3'd5,
        S_REL   = 3'd6,
        S_RELX  = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic       s1_q, s2_q, s3_q;
    logic       fall;
    logic [3:0] edge_cnt_q, edge_cnt_d, cnt_dec;
    logic [1:0] bit_idx_q, bit_idx_d;
    logic [2:0] tok_q, tok_d;
    logic       dat0_out_q, dat0_out_d;
    logic       dat0_oe_q, dat0_oe_d;
    logic       busy_q, busy_d;
    logic       status_done_q, status_done_d;
    logic       crc_error_q, crc_error_d;
    logic       overrun_q, overrun_d;

    // Falling edge of the synchronised sd_clock, one system clock wide.
    assign fall    = s3_q & ~s2_q;
    assign cnt_dec = (edge_cnt_q == 4'd0) ? 4'd0 : edge_cnt_q - 4'd1;

    // State register, synchroniser and registered outputs; reset releases DAT0 at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            edge_cnt_q    <= 4'd0;
            bit_idx_q     <= 2'd0;
            tok_q         <= 3'd0;
            dat0_out_q    <= 1'b1;
            dat0_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
            status_done_q <= 1'b0;
            crc_error_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= bus.sd_clock;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            edge_cnt_q    <= edge_cnt_d;
            bit_idx_q     <= bit_idx_d;
            tok_q         <= tok_d;
            dat0_out_q    <= dat0_out_d;
            dat0_oe_q     <= dat0_oe_d;
            busy_q        <= busy_d;
            status_done_q <= status_done_d;
            crc_error_q   <= crc_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state and counter logic; abort beats a simultaneous fall pulse.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_idx_d  = bit_idx_q;
        tok_d      = tok_q;
        if (state_q == S_IDLE) begin
            if (bus.write_all_strobe && !bus.abort) begin
                // tok[1] doubles as the "positive token" flag downstream.
                tok_d      = bus.crc_ok ? 3'b010 : 3'b101;
                edge_cnt_d = 4'(NCRC_EDGES);
                state_d    = S_WAIT;
            end
        end else if (bus.abort) begin
            state_d = S_IDLE;
        end else if (fall) begin
            case (state_q)
                S_WAIT: begin
                    edge_cnt_d = cnt_dec;
                    if (cnt_dec == 4'd0) state_d = S_START;
                end
                S_START: begin
                    bit_idx_d = 2'd2;
                    state_d   = S_STAT;
                end
                S_STAT: begin
                    if (bit_idx_q == 2'd0) state_d = S_END;
                    else                   bit_idx_d = bit_idx_q - 2'd1;
                end
                S_END: begin
                    if (tok_q[1]) begin
                        edge_cnt_d = 4'(BUSY_MIN);
                        state_d    = S_BUSY;
                    end else begin
                        state_d = S_REL;
                    end
                end
                S_BUSY: begin
                    // The decremented count decides, so BUSY_MIN=1 yields one busy bit.
                    edge_cnt_d = cnt_dec;
                    if (cnt_dec == 4'd0 && !bus.busy_hold) state_d = S_REL;
                end
                S_REL:   state_d = S_RELX;
                S_RELX:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: DAT0 value/enable and status pulses for the next cycle.
    always_comb begin
        dat0_out_d    = dat0_out_q;
        dat0_oe_d     = dat0_oe_q;
        busy_d        = busy_q;
        status_done_d = 1'b0;
        crc_error_d   = 1'b0;
        overrun_d     = overrun_q;
        if (bus.write_all_strobe && state_q != S_IDLE) overrun_d = 1'b1;
        if (state_q != S_IDLE && bus.abort) begin
            dat0_out_d = 1'b1;
            dat0_oe_d  = 1'b0;
            busy_d     = 1'b0;
        end else if (fall) begin
            case (state_q)
                S_START: begin
                    dat0_out_d = 1'b0;
                    dat0_oe_d  = 1'b1;
                    busy_d     = 1'b1;
                end
                S_STAT:  dat0_out_d = tok_q[bit_idx_q];
                S_END: begin
                    dat0_out_d  = 1'b1;
                    crc_error_d = ~tok_q[1];
                end
                S_BUSY:  dat0_out_d = 1'b0;
                S_REL:   dat0_out_d = 1'b1;
                S_RELX: begin
                    dat0_out_d    = 1'b1;
                    dat0_oe_d     = 1'b0;
                    busy_d        = 1'b0;
                    status_done_d = tok_q[1];
                end
                default: ;
            endcase
        end
    end

    assign bus.dat0_out    = dat0_out_q;
    assign bus.dat0_oe     = dat0_oe_q;
    assign bus.busy        = busy_q;
    assign bus.status_done = status_done_q;
    assign bus.crc_error   = crc_error_q;
    assign bus.overrun     = overrun_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sd_write_crc_status.sv
// Bench for sd_write_crc_status: host-side DAT0 sampler on sd_clock rising
// edges checked against an expected queue of {oe,out} events, plus direct
// checks of status pulses, overrun, abort and asynchronous reset.
module tb_sd_write_crc_status;

    logic clock;
    logic reset_n;

    sd_write_crc_status_if bus();

    sd_write_crc_status #(.NCRC_EDGES(2), .BUSY_MIN(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Expected host-visible events: 2'b1x = driven bit x, 2'b00 = line released.
    logic [1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int busy_edges, done_cnt, crcerr_cnt, busy_state_cycles;
    logic prev_oe = 1'b0;

    // Clock/reset block: 10 ns system clock, 80 ns sd_clock offset from clock edges.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        bus.sd_clock = 1'b0;
        #3;
        forever #40 bus.sd_clock = ~bus.sd_clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: host samples DAT0 on sd_clock rising edges.
    always @(posedge bus.sd_clock) begin : monitor
        logic [1:0] got;
        logic       fire;
        got  = {bus.dat0_oe, bus.dat0_out};
        fire = 1'b0;
        if (bus.dat0_oe) begin
            fire = 1'b1;
        end else if (prev_oe) begin
            got  = 2'b00;
            fire = 1'b1;
        end
        prev_oe = bus.dat0_oe;
        if (fire) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL monitor_unexpected: got %b expected no event", got);
            end else begin
                check("monitor_dat0", got, exp_q.pop_front());
            end
        end
    end

    always @(posedge bus.sd_clock) if (bus.busy) busy_edges++;

    always @(negedge clock) begin
        if (bus.status_done) done_cnt++;
        if (bus.crc_error) crcerr_cnt++;
        if (bus.state_dbg == 3'd5) busy_state_cycles++;
    end

    task automatic clear_counts();
        busy_edges        = 0;
        done_cnt          = 0;
        crcerr_cnt        = 0;
        busy_state_cycles = 0;
    endtask

    // Driver: strobe just after an sd_clock rising edge (P0) so falls are countable.
    task automatic start_token(input logic ok);
        @(posedge bus.sd_clock);
        @(negedge clock);
        bus.write_all_strobe = 1'b1;
        bus.crc_ok           = ok;
        @(negedge clock);
        bus.write_all_strobe = 1'b0;
    endtask

    // Token bits on the wire, start bit first.
    task automatic push_seq(input logic [4:0] bits);
        for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, bits[i]});
    endtask

    task automatic push_n(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, v});
    endtask

    task automatic push_release();
        exp_q.push_back(2'b00);
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge bus.sd_clock);
            #1;
            if (exp_q.size() == 0 && !bus.dat0_oe) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_completed"}, ok, 1);
        repeat (4) @(negedge clock);
    endtask

    localparam logic [4:0] TOK_POS = 5'b00101;
    localparam logic [4:0] TOK_NEG = 5'b01011;

    initial begin
        int n;
        reset_n              = 1'b0;
        bus.write_all_strobe = 1'b0;
        bus.crc_ok           = 1'b0;
        bus.busy_hold        = 1'b0;
        bus.abort            = 1'b0;
        clear_counts();

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_dat0_out", bus.dat0_out, 1);
        check("rst_dat0_oe", bus.dat0_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_status_done", bus.status_done, 0);
        check("rst_crc_error", bus.crc_error, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_state", bus.state_dbg, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Positive token: 2 undriven edges, 0,0,1,0,1, busy 0, 1, release.
        clear_counts();
        push_seq(TOK_POS);
        push_n(1'b0, 1);
        push_n(1'b1, 1);
        push_release();
        start_token(1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge bus.sd_clock);
            #1;
            if (bus.dat0_oe) break;
            n++;
        end
        check("pos_undriven_edges", n, 2);
        wait_done("pos");
        check("pos_busy_edges", busy_edges, 7);
        check("pos_status_done", done_cnt, 1);
        check("pos_crc_error", crcerr_cnt, 0);
        check("pos_overrun", bus.overrun, 0);

        // Negative token: 0,1,0,1,1, then 1, release; no BUSY state.
        clear_counts();
        push_seq(TOK_NEG);
        push_n(1'b1, 1);
        push_release();
        start_token(1'b0);
        wait_done("neg");
        check("neg_busy_edges", busy_edges, 6);
        check("neg_crc_error", crcerr_cnt, 1);
        check("neg_status_done", done_cnt, 0);
        check("neg_busy_state_cycles", busy_state_cycles, 0);

        // busy_hold extends busy to 20 low bits (drop after P26).
        clear_counts();
        bus.busy_hold = 1'b1;
        push_seq(TOK_POS);
        push_n(1'b0, 20);
        push_n(1'b1, 1);
        push_release();
        start_token(1'b1);
        repeat (26) @(posedge bus.sd_clock);
        @(negedge clock);
        bus.busy_hold = 1'b0;
        wait_done("hold");
        check("hold_busy_edges", busy_edges, 26);
        check("hold_status_done", done_cnt, 1);
        check("hold_crc_error", crcerr_cnt, 0);

        // Abort after the first status bit, then a fresh complete token.
        clear_counts();
        push_n(1'b0, 2);
        push_release();
        start_token(1'b1);
        repeat (4) @(posedge bus.sd_clock);
        @(negedge clock);
        bus.abort = 1'b1;
        @(posedge clock);
        #1;
        check("abort_oe", bus.dat0_oe, 0);
        check("abort_out", bus.dat0_out, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_state", bus.state_dbg, 0);
        @(negedge clock);
        bus.abort = 1'b0;
        wait_done("abort");
        check("abort_status_done", done_cnt, 0);
        check("abort_crc_error", crcerr_cnt, 0);
        clear_counts();
        push_seq(TOK_POS);
        push_n(1'b0, 1);
        push_n(1'b1, 1);
        push_release();
        start_token(1'b1);
        wait_done("after_abort");
        check("after_abort_status_done", done_cnt, 1);

        // abort together with strobe in IDLE: nothing starts, no overrun.
        @(negedge clock);
        bus.abort            = 1'b1;
        bus.write_all_strobe = 1'b1;
        bus.crc_ok           = 1'b1;
        @(negedge clock);
        bus.abort            = 1'b0;
        bus.write_all_strobe = 1'b0;
        check("idle_abort_state", bus.state_dbg, 0);
        check("idle_abort_overrun", bus.overrun, 0);
        repeat (6) @(posedge bus.sd_clock);
        #1;
        check("idle_abort_oe", bus.dat0_oe, 0);

        // Second strobe during BUSY: sticky overrun, token undisturbed.
        clear_counts();
        bus.busy_hold = 1'b1;
        push_seq(TOK_POS);
        push_n(1'b0, 6);
        push_n(1'b1, 1);
        push_release();
        start_token(1'b1);
        repeat (10) @(posedge bus.sd_clock);
        @(negedge clock);
        bus.write_all_strobe = 1'b1;
        bus.crc_ok           = 1'b0;
        @(negedge clock);
        bus.write_all_strobe = 1'b0;
        #1;
        check("ovr_overrun_set", bus.overrun, 1);
        check("ovr_state_busy", bus.state_dbg, 5);
        repeat (2) @(posedge bus.sd_clock);
        @(negedge clock);
        bus.busy_hold = 1'b0;
        wait_done("ovr");
        check("ovr_status_done", done_cnt, 1);
        check("ovr_crc_error", crcerr_cnt, 0);
        repeat (6) @(posedge bus.sd_clock);
        #1;
        check("ovr_overrun_sticky", bus.overrun, 1);
        check("ovr_idle_after", bus.state_dbg, 0);

        // Asynchronous reset while holding the line busy.
        clear_counts();
        bus.busy_hold = 1'b1;
        push_seq(TOK_POS);
        push_n(1'b0, 3);
        push_release();
        start_token(1'b1);
        repeat (10) @(posedge bus.sd_clock);
        #13;
        check("pre_reset_oe", bus.dat0_oe, 1);
        reset_n = 1'b0;
        #1;
        check("areset_oe", bus.dat0_oe, 0);
        check("areset_out", bus.dat0_out, 1);
        check("areset_busy", bus.busy, 0);
        check("areset_overrun", bus.overrun, 0);
        check("areset_state", bus.state_dbg, 0);
        @(negedge clock);
        bus.busy_hold = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_done("areset");

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
